// File: rtl/spi_tx_framer_pkg.sv
// spi_framer_pkg: shared types and constants for the SPI transmit framer.
//   state_t       framer FSM states
//   HDR_BYTES     sync + seq + length bytes ahead of the payload
//   TRL_BYTES     checksum bytes after the payload
//   DEF_SYNC_BYTE default first byte of every frame
package spi_framer_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;
    localparam int HDR_BYTES = 3;
    localparam int TRL_BYTES = 1;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/spi_tx_framer_if.sv
// spi_tx_framer_if: sample input stream plus transceiver byte handshake.
//   s_valid/s_ready/s_data  16-bit sample stream into the framer
//   tx_start/tx_data        byte request towards the transceiver
//   tx_busy                 transceiver busy flag
//   master = framer side, slave = source/transceiver side
interface spi_tx_framer_if;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    modport master (input s_valid, s_data, tx_busy, output s_ready, tx_start, tx_data);
    modport slave (output s_valid, s_data, tx_busy, input s_ready, tx_start, tx_data);
endinterface

// File: rtl/spi_tx_framer_fifo.sv
// sample_fifo: show-ahead 16-bit FIFO with registered occupancy.
//   clk/rst  clock, synchronous active-high reset
//   push     write wdata (caller guarantees !full)
//   pop      drop the head (caller guarantees not empty)
//   rdata    current head sample
//   level    occupancy, full when equal to DEPTH
module sample_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [15:0]             wdata,
    output logic [15:0]             rdata,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    always_comb begin
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop ? rd_q + AW'(1) : rd_q;
        cnt_d = push && !pop ? cnt_q + ONE : pop && !push ? cnt_q - ONE : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    assign rdata = mem_q[rd_q];
    assign level = cnt_q;
    assign full  = cnt_q == FULL_CNT;
endmodule

// File: rtl/spi_tx_framer.sv
// spi_tx_framer: buffers samples and issues sync/seq/len/payload/chk frames to an SPI transceiver.
//   clk/rst       clock, synchronous active-high reset
//   enable        permits a new frame to start (sampled in IDLE only)
//   bus           sample stream in, tx_start/tx_data/tx_busy byte handshake out
//   frame_active  high from the first tx_start through frame_done
//   frame_done    one-cycle pulse after the checksum byte completes
//   seq_num       sequence number of the next or current frame
//   fifo_level    buffered sample count
module spi_tx_framer
    import spi_framer_pkg::*;
#(
    parameter int         FRAME_SAMPLES = 4,
    parameter int         FIFO_DEPTH    = 16,
    parameter logic [7:0] SYNC_BYTE     = DEF_SYNC_BYTE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    spi_tx_framer_if.master              bus,
    output logic                         frame_active,
    output logic                         frame_done,
    output logic [7:0]                   seq_num,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
    localparam int FRAME_BYTES = HDR_BYTES + 2 * FRAME_SAMPLES + TRL_BYTES;
    localparam logic [8:0] LAST_IDX = 9'(FRAME_BYTES - 1);
    localparam logic [8:0] END_IDX = 9'(FRAME_BYTES);
    // High bytes sit at even offsets from the header, so their index parity is fixed.
    localparam logic HI_PAR = 1'(HDR_BYTES % 2);
    state_t      state_q, state_d;
    logic [8:0]  idx_q, idx_d;
    logic [7:0]  seq_q, seq_d, chk_q, chk_d, hold_q, hold_d, txd_q, txd_d, cur_byte;
    logic [15:0] head;
    logic        push, pop, full, issue, is_hi;
    logic [$clog2(FIFO_DEPTH):0] level;
    assign push = bus.s_valid && !full;
    sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (bus.s_data),
        .rdata (head),
        .level (level),
        .full  (full)
    );
    always_comb begin
        issue    = state_q == ISSUE;
        is_hi    = idx_q >= 9'(HDR_BYTES) && idx_q != LAST_IDX && idx_q[0] == HI_PAR;
        cur_byte = idx_q == 9'd0 ? SYNC_BYTE :
                   idx_q == 9'd1 ? seq_q :
                   idx_q == 9'd2 ? 8'(FRAME_SAMPLES) :
                   idx_q == LAST_IDX ? chk_q :
                   is_hi ? head[15:8] : hold_q;
        pop      = issue && is_hi;
        state_d  = state_q;
        idx_d    = idx_q;
        seq_d    = seq_q;
        chk_d    = chk_q;
        hold_d   = hold_q;
        txd_d    = txd_q;
        case (state_q)
            IDLE: state_d = enable && int'(level) >= FRAME_SAMPLES && !bus.tx_busy ? ISSUE : IDLE;
            ISSUE: begin
                txd_d   = cur_byte;
                chk_d   = idx_q == 9'd0 || idx_q == LAST_IDX ? chk_q : chk_q ^ cur_byte;
                hold_d  = is_hi ? head[7:0] : hold_q;
                idx_d   = idx_q + 9'd1;
                state_d = WAIT_HI;
            end
            WAIT_HI: state_d = bus.tx_busy ? WAIT_LO : WAIT_HI;
            WAIT_LO: state_d = bus.tx_busy ? WAIT_LO : idx_q == END_IDX ? DONE : ISSUE;
            DONE: begin
                seq_d   = seq_q + 8'd1;
                chk_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            seq_q   <= '0;
            chk_q   <= '0;
            hold_q  <= '0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            chk_q   <= chk_d;
            hold_q  <= hold_d;
            txd_q   <= txd_d;
        end
    end
    assign bus.tx_start = issue;
    assign bus.tx_data  = issue ? cur_byte : txd_q;
    assign bus.s_ready  = !full;
    assign frame_active = state_q != IDLE;
    assign frame_done   = state_q == DONE;
    assign seq_num      = seq_q;
    assign fifo_level   = level;
endmodule

// File: tb/tb_spi_tx_framer.sv
// tb_spi_tx_framer: randomized self-checking bench with a frame-level reference model.
module tb_spi_tx_framer;
    localparam int FS = 4;
    localparam logic [7:0] SYNC = 8'hA5;
    logic clk = 0, rst = 1, enable = 0;
    logic frame_active, frame_done;
    logic [7:0] seq_num;
    logic [4:0] fifo_level;
    spi_tx_framer_if bus();
    spi_tx_framer dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .bus          (bus),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .seq_num      (seq_num),
        .fifo_level   (fifo_level)
    );
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [15:0] ref_q[$];
    logic [7:0]  got[$];
    logic [7:0]  seq_m = 0;
    int done_cnt = 0, exp_done = 0, overlap_err = 0, timing_err = 0;
    int left = 0;
    bit pend = 0, fell = 0, mon_en = 1;

    // Transceiver model: busy rises one cycle after tx_start and stays high for 10 cycles.
    always @(negedge clk) begin
        if (mon_en && fell && !(bus.tx_start || frame_done)) timing_err++;
        if (bus.tx_start && bus.tx_busy) overlap_err++;
        if (bus.tx_start) got.push_back(bus.tx_data);
        if (frame_done) done_cnt++;
        if (left > 0) left--;
        if (pend) begin
            pend = 0;
            left = 10;
        end
        if (bus.tx_start) pend = 1;
        fell = bus.tx_busy && left == 0;
        bus.tx_busy = left > 0;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] d, output bit ok);
        bus.s_valid = 1;
        bus.s_data = d;
        ok = bus.s_ready;
        if (ok) ref_q.push_back(d);
        tick;
        bus.s_valid = 0;
    endtask

    task automatic push_rand(input int n);
        bit ok;
        for (int i = 0; i < n; i++) push_one(16'($urandom), ok);
    endtask

    task automatic check_frame(input string name);
        logic [7:0] exp[$];
        logic [7:0] chk, b;
        logic [15:0] s;
        int bound = 0, bad = 0;
        while (done_cnt == exp_done && bound < 2000) begin
            tick;
            bound++;
        end
        checks++;
        if (done_cnt == exp_done) begin
            failures++;
            $display("FAIL %s done: frame_done count %0d expected %0d", name, done_cnt, exp_done + 1);
            return;
        end
        exp_done++;
        exp.push_back(SYNC);
        exp.push_back(seq_m);
        exp.push_back(8'(FS));
        chk = seq_m ^ 8'(FS);
        for (int i = 0; i < FS; i++) begin
            s = ref_q.size() > 0 ? ref_q.pop_front() : 16'hxxxx;
            exp.push_back(s[15:8]);
            exp.push_back(s[7:0]);
            chk = chk ^ s[15:8] ^ s[7:0];
        end
        exp.push_back(chk);
        checks++;
        if (got.size() < exp.size()) begin
            failures++;
            $display("FAIL %s bytes: got %0d bytes expected %0d", name, got.size(), exp.size());
            got.delete();
        end else begin
            foreach (exp[i]) begin
                b = got.pop_front();
                if (b !== exp[i]) begin
                    bad++;
                    $display("FAIL %s byte%0d: got %02h expected %02h", name, i, b, exp[i]);
                end
            end
            if (bad > 0) failures++;
        end
        seq_m = seq_m + 8'd1;
        tick;
        checks++;
        if (seq_num !== seq_m) begin
            failures++;
            $display("FAIL %s seq_num: got %02h expected %02h", name, seq_num, seq_m);
        end
    endtask

    task automatic test_reset;
        bus.s_valid = 0;
        bus.s_data = 0;
        rst = 1;
        tick;
        tick;
        rst = 0;
        checks += 7;
        if (bus.tx_start !== 1'b0) begin failures++; $display("FAIL reset tx_start: got %b expected 0", bus.tx_start); end
        if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset tx_data: got %02h expected 00", bus.tx_data); end
        if (frame_active !== 1'b0) begin failures++; $display("FAIL reset frame_active: got %b expected 0", frame_active); end
        if (frame_done !== 1'b0) begin failures++; $display("FAIL reset frame_done: got %b expected 0", frame_done); end
        if (seq_num !== 8'h00) begin failures++; $display("FAIL reset seq_num: got %02h expected 00", seq_num); end
        if (fifo_level !== 5'd0) begin failures++; $display("FAIL reset fifo_level: got %0d expected 0", fifo_level); end
        if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL reset s_ready: got %b expected 1", bus.s_ready); end
    endtask

    task automatic test_single_frame;
        logic [15:0] v[4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        bit ok;
        enable = 1;
        foreach (v[i]) push_one(v[i], ok);
        check_frame("single");
        repeat (5) tick;
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL single done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_backpressure;
        int acc = 0, bound = 0;
        bit ok;
        enable = 0;
        for (int i = 0; i < 17; i++) begin
            push_one(16'($urandom), ok);
            acc += int'(ok);
        end
        checks += 3;
        if (acc !== 16) begin failures++; $display("FAIL bp accepted: got %0d expected 16", acc); end
        if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL bp s_ready_full: got %b expected 0", bus.s_ready); end
        if (fifo_level !== 5'd16) begin failures++; $display("FAIL bp fifo_level: got %0d expected 16", fifo_level); end
        enable = 1;
        while (got.size() < 4 && bound < 500) begin
            tick;
            bound++;
        end
        checks += 2;
        if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL bp s_ready_at_pop: got %b expected 0", bus.s_ready); end
        tick;
        if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL bp s_ready_after_pop: got %b expected 1", bus.s_ready); end
        for (int i = 0; i < 4; i++) check_frame("bp");
    endtask

    task automatic test_partial;
        bit ok;
        enable = 1;
        push_rand(3);
        repeat (200) tick;
        checks += 2;
        if (got.size() !== 0) begin failures++; $display("FAIL partial tx_bytes: got %0d expected 0", got.size()); end
        if (fifo_level !== 5'd3) begin failures++; $display("FAIL partial fifo_level: got %0d expected 3", fifo_level); end
        push_one(16'($urandom), ok);
        checks += 2;
        if (bus.tx_start !== 1'b0) begin failures++; $display("FAIL partial early_start: got %b expected 0", bus.tx_start); end
        tick;
        if (bus.tx_start !== 1'b1) begin failures++; $display("FAIL partial start_latency: got %b expected 1", bus.tx_start); end
        check_frame("partial");
    endtask

    task automatic test_enable_drop;
        int bound = 0;
        enable = 1;
        push_rand(8);
        while (got.size() < 5 && bound < 500) begin
            tick;
            bound++;
        end
        enable = 0;
        check_frame("endrop");
        repeat (100) tick;
        checks += 3;
        if (got.size() !== 0) begin failures++; $display("FAIL endrop extra_bytes: got %0d expected 0", got.size()); end
        if (frame_active !== 1'b0) begin failures++; $display("FAIL endrop frame_active: got %b expected 0", frame_active); end
        if (fifo_level !== 5'd4) begin failures++; $display("FAIL endrop fifo_level: got %0d expected 4", fifo_level); end
    endtask

    task automatic test_seq_wrap;
        enable = 1;
        check_frame("wrap_flush");
        while (seq_m != 8'hFF) begin
            push_rand(FS);
            check_frame("wrap");
        end
        checks++;
        if (seq_num !== 8'hFF) begin failures++; $display("FAIL wrap seq_ff: got %02h expected ff", seq_num); end
        push_rand(FS);
        check_frame("wrap_ff");
        checks++;
        if (seq_num !== 8'h00) begin failures++; $display("FAIL wrap seq_00: got %02h expected 00", seq_num); end
        push_rand(FS);
        check_frame("wrap_00");
    endtask

    task automatic test_handshake_rules;
        checks += 2;
        if (overlap_err !== 0) begin failures++; $display("FAIL rules start_while_busy: got %0d expected 0", overlap_err); end
        if (timing_err !== 0) begin failures++; $display("FAIL rules restart_timing: got %0d expected 0", timing_err); end
    endtask

    task automatic test_reset_mid;
        int bound = 0;
        enable = 1;
        push_rand(FS);
        while (got.size() < 6 && bound < 500) begin
            tick;
            bound++;
        end
        mon_en = 0;
        tick;
        tick;
        rst = 1;
        tick;
        checks += 5;
        if (bus.tx_start !== 1'b0) begin failures++; $display("FAIL rstmid tx_start: got %b expected 0", bus.tx_start); end
        if (fifo_level !== 5'd0) begin failures++; $display("FAIL rstmid fifo_level: got %0d expected 0", fifo_level); end
        if (seq_num !== 8'h00) begin failures++; $display("FAIL rstmid seq_num: got %02h expected 00", seq_num); end
        if (frame_done !== 1'b0) begin failures++; $display("FAIL rstmid frame_done: got %b expected 0", frame_done); end
        if (frame_active !== 1'b0) begin failures++; $display("FAIL rstmid frame_active: got %b expected 0", frame_active); end
        rst = 0;
        ref_q.delete();
        got.delete();
        seq_m = 0;
        repeat (30) tick;
        checks++;
        if (done_cnt !== exp_done) begin failures++; $display("FAIL rstmid spurious_done: got %0d expected %0d", done_cnt, exp_done); end
        mon_en = 1;
        push_rand(FS);
        check_frame("after_rst");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_partial();
        test_enable_drop();
        test_seq_wrap();
        test_handshake_rules();
        test_reset_mid();
        test_handshake_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_tx_framer.md
# spi_tx_framer

Packetizing stage that sits directly upstream of the SPI transceiver's byte-transmit port. It buffers 16-bit audio samples in an internal FIFO, wraps each group of FRAME_SAMPLES samples in a frame (sync, sequence, length, payload, checksum), and issues the frame byte-by-byte via the transceiver's tx_start / tx_data / tx_busy handshake. One frame is in flight at a time. Byte serialisation on the wire belongs to the transceiver.

## Interface
Parameters:
- FRAME_SAMPLES, 4: samples per frame; range 1..127.
- FIFO_DEPTH, 16: sample FIFO depth; power of two, ≥ FRAME_SAMPLES.
- SYNC_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high; clock clk.
- enable  in  1  allows a new frame to start; sampled only in IDLE.
- s_valid  in  1  sample-input valid.
- s_ready  out  1  sample-input ready; equals !full.
- s_data  in  16  audio sample, transmitted MSB byte first.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  out  8  byte to send; valid on the tx_start cycle and held until the next tx_start.
- tx_busy  in  1  transceiver busy flag.
- frame_active  out  1  high from the first tx_start of a frame through the frame_done cycle.
- frame_done  out  1  one-cycle pulse when the checksum byte completes.
- seq_num  out  8  sequence number of the next or current frame.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Frame byte order:
  - SYNC_BYTE
  - seq_num
  - FRAME_SAMPLES (8-bit)
  - for each sample: s_data[15:8], then s_data[7:0]
  - CHK
- Total frame length is 4 + 2·FRAME_SAMPLES bytes.
- CHK is the XOR of all bytes after SYNC: seq, len and payload. It is accumulated as bytes are issued.
- FIFO behaviour:
  - Push on s_valid && s_ready.
  - Pop when a sample's high byte is issued; the low byte comes from a holding register.
  - Simultaneous push and pop leaves the level unchanged.
  - Pushing while full is impossible because s_ready = 0.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE.
  - IDLE → ISSUE when enable && fifo_level ≥ FRAME_SAMPLES && !tx_busy.
  - ISSUE: drive tx_start=1 and tx_data=current byte; update the checksum; pop the FIFO if the byte is a high byte; go to WAIT_HI.
  - WAIT_HI: wait for tx_busy=1, then go to WAIT_LO.
  - WAIT_LO: on tx_busy=0, go to ISSUE if bytes remain, otherwise go to DONE.
  - DONE: pulse frame_done, increment seq_num (255 wraps to 0), clear the checksum, go to IDLE.
- Deasserting enable mid-frame does not abort: the current frame completes, and no new frame starts.
- When fewer than FRAME_SAMPLES samples are buffered, the block stays in IDLE; partial frames are never sent.
- Only rst aborts a frame.

## Timing
- Reset values:
  - tx_start=0, tx_data=0
  - frame_active=0, frame_done=0
  - seq_num=0, fifo_level=0, s_ready=1
  - FIFO empty, checksum 0, state IDLE
- Latency: the first tx_start occurs 1 cycle after the IDLE start condition is true.
- The next tx_start occurs exactly 1 cycle after tx_busy is seen falling in WAIT_LO.
- frame_done occurs 1 cycle after the CHK byte's tx_busy falls.
- tx_start is never asserted while tx_busy=1.
- fifo_level and s_ready are registered and update the cycle after push/pop.
- Boundaries:
  - FIFO full with a pop in the same cycle: s_ready returns the following cycle.
  - fifo_level reaches FRAME_SAMPLES exactly in IDLE: the frame starts.
  - rst mid-frame: all state clears; the transceiver finishes its current byte unaided.

## Structure
- Package spi_framer_pkg holds:
  - the state enum
  - HDR_BYTES=3 and TRL_BYTES=1
  - the default SYNC_BYTE
- Sub-module sample_fifo (16-bit, FIFO_DEPTH, registered count, synchronous rst) is instantiated once.
- The framer FSM, byte counter, checksum and seq register live in the top level.

## Test plan
- Reset: assert rst for 2 cycles → all outputs at their reset values, s_ready=1.
- Single frame: FRAME_SAMPLES=4, push 0x1234, 0x5678, 0x9ABC, 0xDEF0 with enable=1; the transceiver model asserts busy 1 cycle after tx_start for 10 cycles → tx_data sequence A5 00 04 12 34 56 78 9A BC DE F0 04; one frame_done pulse; seq_num becomes 1.
- Backpressure: enable=0, push 17 samples back-to-back → s_ready=0 after the 16th, fifo_level=16, 17th not accepted. Then enable=1 → frame starts and s_ready returns after the first pop.
- Partial frame: push 3 samples with enable=1 → no tx_start for 200 cycles. Push the 4th → frame starts.
- Enable drop and sequence wrap: deassert enable after the 5th byte → the frame completes with a correct CHK, and no second frame starts. Preload seq to 255 via 255 frames → the next frame carries seq 0xFF, then 0x00.
- Reset mid-frame: assert rst during WAIT_LO of byte 6 → the next cycle shows tx_start=0, fifo_level=0, seq_num=0, and no frame_done.
